// File: rtl/nv_fifo_ctl_16x256.sv
// 16-deep x 256-bit valid/ready FIFO controller driving a two-port RAM.
// The RAM's registered read address acts as the FIFO head, so there is no output data register.
module nv_fifo_ctl_16x256 (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_pvld,
    output logic         wr_prdy,
    input  logic [255:0] wr_pd,
    output logic         rd_pvld,
    input  logic         rd_prdy,
    output logic [255:0] rd_pd,
    output logic [4:0]   rd_count,
    output logic         ram_we,
    output logic [3:0]   ram_wa,
    output logic [255:0] ram_di,
    output logic         ram_re,
    output logic [3:0]   ram_ra,
    input  logic [255:0] ram_dout,
    input  logic [31:0]  pwrbus_ram_pd,
    output logic [31:0]  ram_pd
);

    localparam logic [4:0] DEPTH = 5'd16;

    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] count;
    logic [4:0] count_next;
    logic       wr_prdy_q;
    logic       rd_pvld_q;
    logic       push;
    logic       pop;

    assign push = wr_pvld & wr_prdy_q;
    assign pop  = rd_pvld_q & rd_prdy;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 5'd1;
        end else if (pop && !push) begin
            count_next = count - 5'd1;
        end
    end

    // Ready/valid flags are flopped from count_next so they carry no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            count     <= 5'd0;
            wr_prdy_q <= 1'b1;
            rd_pvld_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 4'd1;
            end
            count     <= count_next;
            wr_prdy_q <= (count_next != DEPTH);
            rd_pvld_q <= (count_next != 5'd0);
        end
    end

    assign wr_prdy  = wr_prdy_q;
    assign rd_pvld  = rd_pvld_q;
    assign rd_count = count;

    assign ram_we = push & ~rst;
    assign ram_wa = wr_ptr;
    assign ram_di = wr_pd;

    // Reload the head on the first push into an empty FIFO, or advance it on a pop when a
    // successor exists (already stored, or being written this very cycle).
    always_comb begin
        ram_re = 1'b0;
        ram_ra = rd_ptr;
        if (count != 5'd0) begin
            ram_ra = rd_ptr + 4'd1;
        end
        if (!rst) begin
            ram_re = ((count == 5'd0) & push) | (pop & ((count > 5'd1) | push));
        end
    end

    assign rd_pd  = ram_dout;
    assign ram_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_fifo_ctl_16x256.sv
// Directed and randomized bench for nv_fifo_ctl_16x256 with a behavioural 16x256 RAM
// and a queue reference model.
module tb_nv_fifo_ctl_16x256;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [255:0] wr_pd;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [255:0] rd_pd;
    logic [4:0]   rd_count;
    logic         ram_we;
    logic [3:0]   ram_wa;
    logic [255:0] ram_di;
    logic         ram_re;
    logic [3:0]   ram_ra;
    logic [255:0] ram_dout;
    logic [31:0]  pwrbus_ram_pd;
    logic [31:0]  ram_pd;

    int vector_count = 0;
    int miss_count   = 0;

    always #5 clk = ~clk;

    nv_fifo_ctl_16x256 dut (
        .clk           (clk),
        .rst           (rst),
        .wr_pvld       (wr_pvld),
        .wr_prdy       (wr_prdy),
        .wr_pd         (wr_pd),
        .rd_pvld       (rd_pvld),
        .rd_prdy       (rd_prdy),
        .rd_pd         (rd_pd),
        .rd_count      (rd_count),
        .ram_we        (ram_we),
        .ram_wa        (ram_wa),
        .ram_di        (ram_di),
        .ram_re        (ram_re),
        .ram_ra        (ram_ra),
        .ram_dout      (ram_dout),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .ram_pd        (ram_pd)
    );

    // Behavioural RAM: registered read address held while re is low.
    logic [255:0] mem [16];
    logic [3:0]   ra_d = 4'd0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
    end
    assign ram_dout = mem[ra_d];

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [255:0] data, input logic rp);
        wr_pvld = wv;
        wr_pd   = data;
        rd_prdy = rp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] model_q [$];
    logic [3:0]   addr_q [$];
    logic [15:0]  occupied;
    logic [255:0] held_pd;
    logic         hold_pending;
    logic [255:0] data_word;
    logic [3:0]   wa_cap;
    logic [3:0]   freed;
    logic         m_push;
    logic         m_pop;

    initial begin
        pwrbus_ram_pd = 32'hDEAD_BEEF;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        tick();
        tick();
        checkOutput("reset_wr_prdy", wr_prdy, 1);
        checkOutput("reset_rd_pvld", rd_pvld, 0);
        checkOutput("reset_count", rd_count, 0);
        checkOutput("pwr_passthru", ram_pd, 32'hDEAD_BEEF);
        applyStimulus(1'b1, {32{8'hA5}}, 1'b0);
        checkOutput("reset_we_low", ram_we, 0);
        checkOutput("reset_re_low", ram_re, 0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        tick();

        // Single push then pop
        applyStimulus(1'b1, {32{8'hA5}}, 1'b0);
        checkOutput("single_we", ram_we, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("single_pvld", rd_pvld, 1);
        checkOutput("single_pd", rd_pd, {32{8'hA5}});
        checkOutput("single_count", rd_count, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("single_pvld_after_pop", rd_pvld, 0);
        checkOutput("single_count_after_pop", rd_count, 0);

        // Fill to 16 and hold a 17th word
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 256'(i), 1'b0);
            checkOutput("fill_prdy", wr_prdy, 1);
            tick();
        end
        checkOutput("full_count", rd_count, 16);
        checkOutput("full_prdy", wr_prdy, 0);
        applyStimulus(1'b1, 256'd16, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("full_no_we", ram_we, 0);
            tick();
            checkOutput("full_hold_count", rd_count, 16);
        end
        checkOutput("full_head", rd_pd, 0);
        applyStimulus(1'b1, 256'd16, 1'b1);
        checkOutput("full_pop_prdy_same", wr_prdy, 0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("full_pop_prdy_next", wr_prdy, 1);
        checkOutput("full_pop_count", rd_count, 15);
        for (int i = 1; i < 16; i++) begin
            checkOutput("drain_pd", rd_pd, 256'(i));
            applyStimulus(1'b0, '0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("drain_empty", rd_pvld, 0);

        // Streaming push+pop every cycle, 40 cycles
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 256'(k), 1'b1);
            if (k > 0) begin
                checkOutput("stream_pd", rd_pd, 256'(k - 1));
                checkOutput("stream_count", rd_count, 1);
            end
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("stream_last", rd_pd, 256'd39);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("stream_empty", rd_count, 0);

        // Push and pop at occupancy 1
        applyStimulus(1'b1, 256'h11, 1'b0);
        tick();
        applyStimulus(1'b1, 256'h22, 1'b1);
        checkOutput("occ1_head", rd_pd, 256'h11);
        checkOutput("occ1_ra_eq_wa", ram_ra, ram_wa);
        checkOutput("occ1_re", ram_re, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("occ1_new_pd", rd_pd, 256'h22);
        checkOutput("occ1_count", rd_count, 1);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("occ1_empty", rd_count, 0);

        // Random traffic against the queue model
        occupied     = '0;
        hold_pending = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            data_word = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), data_word, 1'($urandom_range(0, 1)));
            checkOutput("rnd_count", rd_count, 256'(model_q.size()));
            checkOutput("rnd_prdy", wr_prdy, model_q.size() != 16);
            checkOutput("rnd_pvld", rd_pvld, model_q.size() != 0);
            if (model_q.size() != 0) checkOutput("rnd_pd", rd_pd, model_q[0]);
            if (hold_pending) checkOutput("rnd_stable", rd_pd, held_pd);
            m_push = wr_pvld && (model_q.size() != 16);
            m_pop  = rd_prdy && (model_q.size() != 0);
            checkOutput("rnd_we", ram_we, m_push);
            if (ram_we) checkOutput("rnd_we_free", occupied[ram_wa], 0);
            hold_pending = rd_pvld && !rd_prdy;
            held_pd      = rd_pd;
            wa_cap       = ram_wa;
            tick();
            if (m_pop) begin
                void'(model_q.pop_front());
                freed = addr_q.pop_front();
                occupied[freed] = 1'b0;
            end
            if (m_push) begin
                model_q.push_back(data_word);
                addr_q.push_back(wa_cap);
                occupied[wa_cap] = 1'b1;
            end
        end

        // Reset at occupancy 9 during active traffic
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 256'(100 + i), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 256'd200, 1'b1);
        tick();
        checkOutput("pre_rst_count", rd_count, 9);
        rst = 1'b1;
        applyStimulus(1'b1, 256'd201, 1'b1);
        checkOutput("rst_we_low", ram_we, 0);
        checkOutput("rst_re_low", ram_re, 0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_count", rd_count, 0);
        checkOutput("post_rst_pvld", rd_pvld, 0);
        checkOutput("post_rst_prdy", wr_prdy, 1);
        applyStimulus(1'b1, 256'h33, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("post_rst_pd", rd_pd, 256'h33);
        checkOutput("post_rst_count1", rd_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/nv_fifo_ctl_16x256.md
# nv_fifo_ctl_16x256

Valid/ready FIFO controller that owns the write and read ports of the 16-entry x 256-bit two-port RAM (`nv_ram_rws_16x256`). It sits between a producer and a consumer and turns the RAM into a 16-deep, 1-entry-per-cycle FIFO. The RAM's registered read address is used as the FIFO head, so no separate output data register exists. The block generates `we/wa/di` and `re/ra`, and consumes `dout` as the read payload.

## Interface
- Parameters: none. Depth is fixed at 16 and width at 256.
- Ports (`clk` and `rst` first):
- clk  in  1  single clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- wr_pvld  in  1  producer data valid
- wr_prdy  out  1  FIFO can accept; registered, no combinational path from any input
- wr_pd  in  256  producer payload
- rd_pvld  out  1  head entry valid; registered
- rd_prdy  in  1  consumer accepts head
- rd_pd  out  256  head payload; wired from ram_dout
- rd_count  out  5  occupancy 0..16; registered
- ram_we  out  1  to RAM `we`
- ram_wa  out  4  to RAM `wa`
- ram_di  out  256  to RAM `di`; equals wr_pd
- ram_re  out  1  to RAM `re`
- ram_ra  out  4  to RAM `ra`
- ram_dout  in  256  from RAM `dout`; equals M[ra_d]
- pwrbus_ram_pd  in  32  power bus; passed unmodified to ram_pd
- ram_pd  out  32  to RAM `pwrbus_ram_pd`

## Operation
- State: `wr_ptr[3:0]` (next write slot), `rd_ptr[3:0]` (current head slot), `count[4:0]`.
- Invariant: `wr_ptr == (rd_ptr + count) mod 16`. When `count == 0`, `rd_ptr == wr_ptr`.
- push = wr_pvld & wr_prdy; pop = rd_pvld & rd_prdy.
- wr_prdy = (count != 16). rd_pvld = (count != 0). rd_count = count.
- Write port: ram_we = push & !rst; ram_wa = wr_ptr; wr_ptr += push, wrapping 15 -> 0.
- Read port: ram_re = !rst & ((count == 0 & push) | (pop & (count > 1 | push))).
- ram_ra = (count == 0) ? rd_ptr : rd_ptr + 1, mod 16.
- rd_ptr += pop, wrapping.
- count_next = count + push - pop.
- The head slot stays occupied until popped. It is never overwritten while displayed, so ram_dout remains stable while rd_pvld is high and no pop occurs.
- Push and pop in the same cycle at count == 1: ram_re and ram_we target the same address (rd_ptr + 1 == wr_ptr). The RAM write and `ra_d` update land on the same edge, so the new data appears on rd_pd the next cycle. This case is required to work.
- Full (count == 16): wr_prdy = 0. A pop in that cycle makes wr_prdy = 1 the next cycle. There is no same-cycle write-through when full.
- Empty (count == 0): rd_pvld = 0. rd_pd is don't-care and must not be checked.
- ram_re = 0 leaves RAM `ra_d` unchanged. The controller relies on this hold behaviour.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, so wr_prdy = 1, rd_pvld = 0, rd_count = 0.
- During rst, ram_we = 0 and ram_re = 0.
- Reset mid-operation drops all entries. RAM contents are not cleared and are unreachable afterwards.
- Write-to-read latency: a push in cycle N into an empty FIFO gives rd_pvld = 1 with that data in cycle N+1.
- Throughput: 1 push and 1 pop per cycle sustained at any occupancy 1..15.
- rd_pd is valid in the cycle after ram_re is asserted and holds until the next ram_re.
- No combinational path exists from wr_pvld or rd_prdy to wr_prdy, rd_pvld or rd_count.
- A combinational path exists from wr_pvld/rd_prdy to ram_we/ram_re/ram_ra. This is acceptable because the RAM registers them.
- Producer rule: wr_pd must be stable while wr_pvld is high and wr_prdy is low.
- Consumer rule: no requirement. rd_prdy may toggle freely.

## Test plan
- Reset then a single push of 0xA5..A5 in cycle 1: rd_pvld = 1 in cycle 2 with rd_pd = 0xA5..A5 and rd_count = 1. Pop in cycle 2 gives rd_pvld = 0 and rd_count = 0 in cycle 3.
- Push 16 incrementing words (0..15) with rd_prdy = 0: wr_prdy drops after the 16th push and rd_count = 16. A 17th wr_pvld held for 5 cycles is not accepted. One pop returns 0, and wr_prdy = 1 the next cycle.
- Streaming with wr_pvld = rd_prdy = 1 for 40 cycles, data = cycle index: output sequence is in order with no gaps after the first 1-cycle latency, pointers wrap twice, and rd_count stays at 1.
- Occupancy 1 with push and pop in the same cycle (head 0x11, new 0x22): next cycle rd_pd = 0x22, rd_count = 1, and ram_ra == ram_wa in the push cycle.
- Random wr_pvld/rd_prdy over 10k cycles against a reference queue model: data matches, rd_count matches, ram_we never targets an occupied slot, and rd_pd is stable while rd_pvld & !rd_prdy.
- rst asserted at occupancy 9 during active push/pop: the next cycle has count = 0, rd_pvld = 0, wr_prdy = 1. ram_we and ram_re are 0 during rst, and a subsequent push of 0x33 reads back 0x33.
